// File: rtl/toggle_decoder_pkg.sv
// Shared types and default parameters for the toggle-encoded event decoder.
package toggle_decoder_pkg;
    localparam int SYNC_STAGES_DEF = 2;
    localparam int CNT_W_DEF       = 8;
    localparam int PEND_MAX_DEF    = 7;
    localparam int PEND_W          = 3;

    typedef enum logic {
        WARMUP = 1'b0,
        RUN    = 1'b1
    } state_e;
endpackage

// File: rtl/toggle_decoder_if.sv
// Consumer-side bus of the toggle decoder: toggle input, clear, event handshake and status.
interface toggle_decoder_if
    import toggle_decoder_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) ();
    logic              tog_in;
    logic              clr;
    logic              evt_ready;
    logic              pulse_out;
    logic              evt_valid;
    logic [CNT_W-1:0]  evt_cnt;
    logic [PEND_W-1:0] pend_cnt;
    logic              overflow;

    modport master (
        output tog_in, clr, evt_ready,
        input  pulse_out, evt_valid, evt_cnt, pend_cnt, overflow
    );

    modport slave (
        input  tog_in, clr, evt_ready,
        output pulse_out, evt_valid, evt_cnt, pend_cnt, overflow
    );
endinterface

// File: rtl/toggle_sync.sv
// Multi-flop level synchronizer for a signal arriving from a foreign clock domain.
module toggle_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic [SYNC_STAGES-1:0] r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_sync <= '0;
        else        r_sync <= {r_sync[SYNC_STAGES-2:0], d};
    end

    assign q = r_sync[SYNC_STAGES-1];
endmodule

// File: rtl/toggle_decoder.sv
// Decodes level changes of a synchronized toggle into pulses, a running event
// count and a small pending-event counter drained by a ready handshake.
module toggle_decoder
    import toggle_decoder_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int CNT_W       = CNT_W_DEF,
    parameter int PEND_MAX    = PEND_MAX_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    toggle_decoder_if.slave  bus
);
    localparam logic [PEND_W-1:0] W_PMAX = PEND_W'(PEND_MAX);
    localparam logic [2:0]        W_WEND = 3'(SYNC_STAGES);

    logic              w_sync;
    logic              r_prev;
    logic              r_edge;
    logic              r_pulse;
    state_e            r_state, w_state_nxt;
    logic [2:0]        r_wcnt, w_wcnt_nxt;
    logic              w_edge_en;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic [PEND_W-1:0] r_pend, w_pend_nxt;
    logic              r_ovf, w_ovf_nxt;
    logic              w_pop, w_full, w_ovf_set;

    toggle_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus.tog_in),
        .q     (w_sync)
    );

    // Warmup lets prev settle onto the synchronized level so the reset-time
    // level of tog_in is never mistaken for an event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= WARMUP;
            r_wcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_wcnt  <= w_wcnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_wcnt_nxt  = r_wcnt;
        w_edge_en   = 1'b0;
        case (r_state)
            WARMUP: begin
                if (r_wcnt == W_WEND) w_state_nxt = RUN;
                else                  w_wcnt_nxt  = r_wcnt + 3'd1;
            end
            RUN:     w_edge_en   = 1'b1;
            default: w_state_nxt = WARMUP;
        endcase
    end

    // The edge is registered once before it acts, so pulse and counters all
    // move together SYNC_STAGES+1 cycles after tog_in is sampled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev  <= 1'b0;
            r_edge  <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_prev  <= w_sync;
            r_edge  <= w_edge_en & (w_sync ^ r_prev);
            r_pulse <= r_edge;
        end
    end

    assign w_pop     = (r_pend != '0) && bus.evt_ready;
    assign w_full    = (r_pend == W_PMAX);
    assign w_ovf_set = r_edge && !w_pop && w_full;

    always_comb begin
        w_pend_nxt = r_pend;
        case ({r_edge, w_pop})
            2'b10:   if (!w_full) w_pend_nxt = r_pend + PEND_W'(1);
            2'b01:   w_pend_nxt = r_pend - PEND_W'(1);
            default: w_pend_nxt = r_pend;
        endcase
    end

    // Dropped events still count; clr and a coincident edge yield a count of 1.
    assign w_cnt_nxt = bus.clr ? CNT_W'(r_edge) : (r_cnt + CNT_W'(r_edge));
    assign w_ovf_nxt = (bus.clr ? 1'b0 : r_ovf) | w_ovf_set;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_pend <= '0;
            r_ovf  <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_pend <= w_pend_nxt;
            r_ovf  <= w_ovf_nxt;
        end
    end

    assign bus.pulse_out = r_pulse;
    assign bus.evt_valid = (r_pend != '0);
    assign bus.evt_cnt   = r_cnt;
    assign bus.pend_cnt  = r_pend;
    assign bus.overflow  = r_ovf;
endmodule

// File: tb/tb_toggle_decoder.sv
// Self-checking bench for toggle_decoder: directed scenarios plus randomized traffic against an event-queue model.
module tb_toggle_decoder;
    import toggle_decoder_pkg::*;

    localparam int S  = 2;
    localparam int CW = 8;
    localparam int PM = 7;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    toggle_decoder_if #(.CNT_W(CW)) bus ();

    toggle_decoder #(.SYNC_STAGES(S), .CNT_W(CW), .PEND_MAX(PM)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: each tog_in level change (after the first sample following
    // reset) becomes an event due S+1 edges later; the counters follow the rules.
    int m_edge, m_pend, m_cnt;
    bit m_ovf, m_pulse, m_last;
    int dueq[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_edge = 0; m_pend = 0; m_cnt = 0; m_ovf = 0; m_pulse = 0;
            dueq.delete();
        end else begin : mdl
            bit evt, pop, ovs;
            m_edge++;
            evt = (dueq.size() > 0) && (dueq[0] == m_edge);
            if (evt) void'(dueq.pop_front());
            pop = (m_pend > 0) && bus.evt_ready;
            ovs = 0;
            if (evt && !pop) begin
                if (m_pend == PM) ovs = 1;
                else              m_pend++;
            end else if (pop && !evt) begin
                m_pend--;
            end
            m_cnt   = bus.clr ? int'(evt) : (m_cnt + int'(evt)) % (1 << CW);
            m_ovf   = (bus.clr ? 1'b0 : m_ovf) | ovs;
            m_pulse = evt;
            if (m_edge == 1) m_last = bus.tog_in;
            else if (bus.tog_in != m_last) begin
                dueq.push_back(m_edge + S + 1);
                m_last = bus.tog_in;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input bit lvl);
        bus.tog_in = lvl; bus.clr = 1'b0; bus.evt_ready = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        bus.tog_in = 1'b1; bus.clr = 1'b0; bus.evt_ready = 1'b0;
        rst_n = 1'b0;
        #2;
        total++;
        if ({bus.pulse_out, bus.evt_valid, bus.overflow, bus.evt_cnt, bus.pend_cnt} !== '0) begin
            bad++; $display("FAIL reset_outputs: got %0h want 0",
                {bus.pulse_out, bus.evt_valid, bus.overflow, bus.evt_cnt, bus.pend_cnt});
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            total++;
            if (bus.pulse_out !== 1'b0) begin
                bad++; $display("FAIL reset_tog1_pulse: cycle %0d got %b want 0", i, bus.pulse_out);
            end
        end
        total++;
        if (bus.evt_cnt !== '0 || bus.evt_valid !== 1'b0) begin
            bad++; $display("FAIL reset_tog1_state: cnt %0d valid %b want 0 0", bus.evt_cnt, bus.evt_valid);
        end
    endtask

    task automatic test_latency();
        do_reset(1'b0);
        repeat (5) tick();
        #6;
        bus.tog_in = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            total++;
            if (bus.pulse_out !== (k == 3)) begin
                bad++; $display("FAIL latency_pulse: edge N+%0d got %b want %b", k, bus.pulse_out, (k == 3));
            end
        end
        total++;
        if (bus.evt_cnt !== 8'd1 || bus.pend_cnt !== 3'd1 || bus.evt_valid !== 1'b1) begin
            bad++; $display("FAIL latency_counts: cnt %0d pend %0d valid %b want 1 1 1",
                bus.evt_cnt, bus.pend_cnt, bus.evt_valid);
        end
    endtask

    task automatic test_overflow();
        int pops;
        logic [2:0] prev;
        do_reset(1'b0);
        repeat (4) tick();
        for (int i = 0; i < 9; i++) begin
            bus.tog_in = ~bus.tog_in;
            repeat (4) tick();
        end
        repeat (2) tick();
        total++;
        if (bus.pend_cnt !== 3'd7 || bus.overflow !== 1'b1 || bus.evt_cnt !== 8'd9) begin
            bad++; $display("FAIL overflow_fill: pend %0d ovf %b cnt %0d want 7 1 9",
                bus.pend_cnt, bus.overflow, bus.evt_cnt);
        end
        bus.evt_ready = 1'b1;
        pops = 0;
        for (int i = 0; i < 10; i++) begin
            prev = bus.pend_cnt;
            tick();
            if (bus.pend_cnt != prev) pops++;
        end
        bus.evt_ready = 1'b0;
        total++;
        if (pops != 7 || bus.pend_cnt !== 3'd0 || bus.evt_valid !== 1'b0) begin
            bad++; $display("FAIL overflow_drain: pops %0d pend %0d valid %b want 7 0 0",
                pops, bus.pend_cnt, bus.evt_valid);
        end
    endtask

    task automatic test_simultaneous();
        do_reset(1'b0);
        repeat (4) tick();
        for (int i = 0; i < 7; i++) begin
            bus.tog_in = ~bus.tog_in;
            repeat (4) tick();
        end
        repeat (2) tick();
        total++;
        if (bus.pend_cnt !== 3'd7 || bus.overflow !== 1'b0) begin
            bad++; $display("FAIL simul_fill: pend %0d ovf %b want 7 0", bus.pend_cnt, bus.overflow);
        end
        bus.tog_in = ~bus.tog_in;
        repeat (3) tick();
        bus.evt_ready = 1'b1;
        tick();
        bus.evt_ready = 1'b0;
        total++;
        if (bus.pend_cnt !== 3'd7 || bus.overflow !== 1'b0 || bus.evt_cnt !== 8'd8) begin
            bad++; $display("FAIL simul_push_pop: pend %0d ovf %b cnt %0d want 7 0 8",
                bus.pend_cnt, bus.overflow, bus.evt_cnt);
        end
        // clr landing on an overflow event keeps overflow set
        bus.tog_in = ~bus.tog_in;
        repeat (3) tick();
        bus.clr = 1'b1;
        tick();
        bus.clr = 1'b0;
        total++;
        if (bus.overflow !== 1'b1 || bus.evt_cnt !== 8'd1 || bus.pend_cnt !== 3'd7) begin
            bad++; $display("FAIL clr_vs_overflow: ovf %b cnt %0d pend %0d want 1 1 7",
                bus.overflow, bus.evt_cnt, bus.pend_cnt);
        end
    endtask

    task automatic test_wrap_clr();
        do_reset(1'b0);
        repeat (4) tick();
        for (int i = 0; i < 256; i++) begin
            bus.tog_in = ~bus.tog_in;
            bus.evt_ready = ($urandom_range(0, 3) != 0);
            tick();
            bus.evt_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        bus.evt_ready = 1'b0;
        repeat (4) tick();
        total++;
        if (bus.evt_cnt !== 8'd0) begin
            bad++; $display("FAIL wrap_256: got %0d want 0", bus.evt_cnt);
        end
        total++;
        if (bus.pend_cnt !== 3'(m_pend) || bus.overflow !== m_ovf) begin
            bad++; $display("FAIL wrap_model: pend %0d ovf %b want %0d %b",
                bus.pend_cnt, bus.overflow, m_pend, m_ovf);
        end
        bus.evt_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.tog_in = ~bus.tog_in;
            repeat (3) tick();
        end
        repeat (10) tick();
        total++;
        if (bus.evt_cnt !== 8'd3) begin
            bad++; $display("FAIL wrap_plus3: got %0d want 3", bus.evt_cnt);
        end
        bus.tog_in = ~bus.tog_in;
        repeat (3) tick();
        bus.clr = 1'b1;
        tick();
        bus.clr = 1'b0;
        bus.evt_ready = 1'b0;
        total++;
        if (bus.evt_cnt !== 8'd1 || bus.overflow !== 1'b0) begin
            bad++; $display("FAIL clr_with_edge: cnt %0d ovf %b want 1 0", bus.evt_cnt, bus.overflow);
        end
    endtask

    task automatic test_random();
        int gap;
        do_reset(1'($urandom_range(0, 1)));
        gap = 0;
        for (int i = 0; i < 400; i++) begin
            tick();
            total++;
            if (bus.pulse_out !== m_pulse || bus.evt_cnt !== CW'(m_cnt) ||
                bus.pend_cnt !== 3'(m_pend) || bus.evt_valid !== (m_pend != 0) ||
                bus.overflow !== m_ovf) begin
                bad++; $display("FAIL random_cycle%0d: p%b c%0d n%0d v%b o%b want p%b c%0d n%0d v%b o%b",
                    i, bus.pulse_out, bus.evt_cnt, bus.pend_cnt, bus.evt_valid, bus.overflow,
                    m_pulse, m_cnt, m_pend, (m_pend != 0), m_ovf);
            end
            gap++;
            if (gap >= 2 && $urandom_range(0, 2) == 0) begin
                bus.tog_in = ~bus.tog_in;
                gap = 0;
            end
            bus.evt_ready = ($urandom_range(0, 2) == 0);
            bus.clr       = ($urandom_range(0, 19) == 0);
        end
        bus.clr = 1'b0;
        bus.evt_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset(1'b0);
        repeat (4) tick();
        for (int i = 0; i < 4; i++) begin
            bus.tog_in = ~bus.tog_in;
            repeat (4) tick();
        end
        repeat (2) tick();
        total++;
        if (bus.pend_cnt !== 3'd4) begin
            bad++; $display("FAIL midreset_fill: got %0d want 4", bus.pend_cnt);
        end
        bus.tog_in = ~bus.tog_in;
        tick();
        #1;
        rst_n = 1'b0;
        #1;
        total++;
        if ({bus.pulse_out, bus.evt_valid, bus.overflow, bus.evt_cnt, bus.pend_cnt} !== '0) begin
            bad++; $display("FAIL midreset_async: got %0h want 0",
                {bus.pulse_out, bus.evt_valid, bus.overflow, bus.evt_cnt, bus.pend_cnt});
        end
        #6;
        rst_n = 1'b1;
        for (int i = 0; i < S + 4; i++) begin
            tick();
            total++;
            if (bus.pulse_out !== 1'b0) begin
                bad++; $display("FAIL midreset_pulse: cycle %0d got %b want 0", i, bus.pulse_out);
            end
        end
        total++;
        if (bus.evt_cnt !== '0 || bus.pend_cnt !== '0) begin
            bad++; $display("FAIL midreset_counts: cnt %0d pend %0d want 0 0", bus.evt_cnt, bus.pend_cnt);
        end
    endtask

    initial begin
        bus.tog_in = 1'b0; bus.clr = 1'b0; bus.evt_ready = 1'b0;
        test_reset();
        test_latency();
        test_overflow();
        test_simultaneous();
        test_wrap_clr();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/toggle_decoder.md
TOGGLE_DECODER -- requirements
Module: toggle_decoder

Interface
REQ-001 Parameter SYNC_STAGES, default 2: synchronizer flop count on tog_in, legal 2..4.
REQ-002 Parameter CNT_W, default 8: width of the event counter.
REQ-003 Parameter PEND_MAX, default 7: maximum pending unacknowledged events, legal 1..7.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-006 tog_in  input  1  toggle level from a negedge T flip-flop in a foreign domain; every level change encodes one event.
REQ-007 clr  input  1  synchronous clear of evt_cnt and overflow.
REQ-008 pulse_out  output  1  one-cycle pulse per decoded event.
REQ-009 evt_valid  output  1  at least one pending event.
REQ-010 evt_ready  input  1  consumer acknowledge; pops one pending event when evt_valid is high.
REQ-011 evt_cnt  output  CNT_W  total decoded events.
REQ-012 pend_cnt  output  3  pending event count.
REQ-013 overflow  output  1  sticky; an event arrived with pend_cnt == PEND_MAX and no pop.

Function
REQ-014 tog_in SHALL pass through SYNC_STAGES flops, then one history flop (prev); edge = sync_out XOR prev.
REQ-015 pulse_out SHALL be the registered edge: a tog_in change set up before rising edge N gives pulse_out high for exactly one cycle after edge N+SYNC_STAGES+1.
REQ-016 Two states SHALL exist: WARMUP and RUN; reset enters WARMUP.
REQ-017 WARMUP SHALL last SYNC_STAGES+1 cycles; prev tracks sync_out; edges are masked (no pulse, no count). It then moves to RUN, and RUN holds until reset.
REQ-018 A tog_in level of 1 at reset release SHALL NOT produce an event.
REQ-019 In RUN, evt_cnt SHALL increment by 1 per edge and wrap modulo 2^CNT_W (all-ones + 1 = 0), including events dropped on overflow.
REQ-020 evt_valid SHALL equal (pend_cnt != 0), driven from registered state.
REQ-021 pend_cnt update: edge only gives +1; pop (evt_valid && evt_ready) only gives -1; both together leave it unchanged; evt_ready with pend_cnt == 0 is ignored.
REQ-022 An edge with pend_cnt == PEND_MAX and no pop SHALL leave pend_cnt at PEND_MAX and set overflow.
REQ-023 An edge with pend_cnt == PEND_MAX and a simultaneous pop SHALL leave pend_cnt unchanged, with no overflow.
REQ-024 clr SHALL zero evt_cnt and overflow next cycle; pend_cnt is unaffected.
REQ-025 clr coincident with an edge SHALL give evt_cnt = 1.
REQ-026 clr coincident with an overflow condition SHALL leave overflow = 1.
REQ-027 Toggles spaced less than 2 clk cycles apart are outside contract; no event-count guarantee.

Reset
REQ-028 rst_n low SHALL asynchronously clear synchronizer flops, prev, pulse_out, evt_cnt, pend_cnt, overflow and evt_valid to 0, and set state to WARMUP.
REQ-029 Reset asserted mid-operation SHALL discard all pending events; no pulse_out for the discarded events.

Structure
REQ-030 Package toggle_decoder_pkg SHALL hold the state enum (WARMUP, RUN) and the default SYNC_STAGES/CNT_W/PEND_MAX constants.
REQ-031 The synchronizer chain SHALL be sub-module toggle_sync (parameter SYNC_STAGES; ports clk, rst_n, d, q).
REQ-032 No combinational path SHALL run from tog_in or evt_ready to any output.

Verification (clk period 10 ns, defaults)
REQ-033 Case 1 (reset with tog_in=1): hold tog_in=1 through reset release, run 20 cycles -> pulse_out never high, evt_cnt=0, evt_valid=0.
REQ-034 Case 2 (latency): after WARMUP, toggle tog_in 0->1 3 ns before edge N -> pulse_out high only in the cycle after edge N+3; evt_cnt=1; pend_cnt=1.
REQ-035 Case 3 (overflow): evt_ready=0, 9 toggles spaced 4 cycles -> pend_cnt=7, overflow=1, evt_cnt=9; then evt_ready=1 for 10 cycles -> 7 pops, pend_cnt=0, evt_valid=0.
REQ-036 Case 4 (simultaneous): pend_cnt=7, evt_ready=1 held, edge arrives in the same cycle as a pop -> pend_cnt stays 7, overflow stays 0.
REQ-037 Case 5 (wrap and clr): 256 toggles -> evt_cnt=0; 3 more -> evt_cnt=3; clr in the same cycle as the next edge -> evt_cnt=1, overflow=0.
REQ-038 Case 6 (reset mid-run): pend_cnt=4, rst_n pulsed low 7 ns asynchronously -> all outputs 0 immediately; no pulse during the next SYNC_STAGES+1 cycles.
